// File: rtl/ctrl_pkg.sv
// Shared control-unit constants: next-address modes, condition selects and
// the fixed control-state numbers used by the sequencer, state encoder and ROM.
package ctrl_pkg;

    localparam int STATE_W     = 7;
    localparam int RESET_STATE = 0;
    localparam int FETCH_STATE = 1;
    localparam int ERROR_STATE = 127;

    // Next-address mode carried in the microinstruction N_Sel field.
    // Codes 3'b110 and 3'b111 are reserved and trap as illegal.
    typedef enum logic [2:0] {
        NS_INC  = 3'b000,
        NS_DISP = 3'b001,
        NS_JMP  = 3'b010,
        NS_BR   = 3'b011,
        NS_WAIT = 3'b100,
        NS_RET  = 3'b101
    } nsel_e;

    // Branch condition source carried in the Cond_Sel field.
    typedef enum logic [1:0] {
        CS_TRUE = 2'b00,
        CS_ZERO = 2'b01,
        CS_NEG  = 2'b10,
        CS_MOC  = 2'b11
    } csel_e;

    // Wait-counter width: enough bits to hold MOC_TIMEOUT, never below one.
    function automatic int moc_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/microsequencer_moc_watchdog.sv
// MOC wait watchdog: counts consecutive wait cycles without memory-complete,
// flags the cycle in which the wait would time out, and keeps a sticky
// bus-error flag that only reset clears.
module moc_watchdog
    import ctrl_pkg::*;
#(
    parameter int MOC_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic wait_mode,
    input  logic moc,
    output logic timeout,
    output logic bus_error
);

    localparam int CNT_W = moc_cnt_width(MOC_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);
    localparam bit               WDOG_EN  = (MOC_TIMEOUT != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_error_q, bus_error_d;

    // Timeout fires on the last allowed MOC-low wait cycle; a late MOC wins.
    always_comb begin
        timeout = 1'b0;
        if (WDOG_EN && wait_mode && !moc && !stall && !bus_error_q &&
            (cnt_q == CNT_LAST)) begin
            timeout = 1'b1;
        end
    end

    // Counter and sticky error next-state; frozen by stall or a latched error.
    always_comb begin
        cnt_d       = cnt_q;
        bus_error_d = bus_error_q;
        if (!bus_error_q && !stall) begin
            if (!wait_mode || moc) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (timeout) begin
                bus_error_d = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error = bus_error_q;

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: holds the control state (the control ROM address)
// and selects the next state from increment, opcode dispatch, literal jump,
// conditional branch, MOC wait or return-to-fetch.
module microsequencer
    import ctrl_pkg::*;
#(
    parameter int STATE_W     = ctrl_pkg::STATE_W,
    parameter int RESET_STATE = ctrl_pkg::RESET_STATE,
    parameter int FETCH_STATE = ctrl_pkg::FETCH_STATE,
    parameter int ERROR_STATE = ctrl_pkg::ERROR_STATE,
    parameter int MOC_TIMEOUT = 255
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Stall,
    input  logic [STATE_W-1:0] State_Sel,
    input  logic [2:0]         N_Sel,
    input  logic [STATE_W-1:0] Cr_Addr,
    input  logic [1:0]         Cond_Sel,
    input  logic               Cond_Inv,
    input  logic               Zero,
    input  logic               Neg,
    input  logic               MOC,
    output logic [STATE_W-1:0] Current_State,
    output logic               Illegal_Op,
    output logic               Instr_Done,
    output logic               Bus_Error
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               illegal_q, illegal_d;
    logic               done_q, done_d;
    logic [STATE_W-1:0] state_inc;
    logic               cond;
    logic               wait_mode;
    logic               timeout;
    logic               bus_error;

    assign state_inc = state_q + STATE_W'(1);
    assign wait_mode = (N_Sel == NS_WAIT);

    moc_watchdog #(
        .MOC_TIMEOUT (MOC_TIMEOUT)
    ) u_watchdog (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .stall     (Stall),
        .wait_mode (wait_mode),
        .moc       (MOC),
        .timeout   (timeout),
        .bus_error (bus_error)
    );

    // Branch condition: selected flag, optionally inverted.
    always_comb begin
        cond = 1'b1;
        case (Cond_Sel)
            CS_TRUE: cond = 1'b1;
            CS_ZERO: cond = Zero;
            CS_NEG:  cond = Neg;
            CS_MOC:  cond = MOC;
            default: cond = 1'b1;
        endcase
        cond = cond ^ Cond_Inv;
    end

    // Next-state mux; a latched bus error or a stall overrides the mode field.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        done_d    = 1'b0;
        if (bus_error) begin
            state_d = STATE_W'(ERROR_STATE);
        end else if (!Stall) begin
            case (N_Sel)
                NS_INC:  state_d = state_inc;
                NS_DISP: begin
                    if (State_Sel != '0) begin
                        state_d = State_Sel;
                    end else begin
                        state_d   = STATE_W'(FETCH_STATE);
                        illegal_d = 1'b1;
                    end
                end
                NS_JMP:  state_d = Cr_Addr;
                NS_BR:   state_d = cond ? Cr_Addr : state_inc;
                NS_WAIT: begin
                    if (MOC) begin
                        state_d = state_inc;
                    end else if (timeout) begin
                        state_d = STATE_W'(ERROR_STATE);
                    end
                end
                NS_RET: begin
                    state_d = STATE_W'(FETCH_STATE);
                    done_d  = 1'b1;
                end
                default: begin
                    state_d   = STATE_W'(FETCH_STATE);
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    // State and pulse registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= STATE_W'(RESET_STATE);
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign Current_State = state_q;
    assign Illegal_Op    = illegal_q;
    assign Instr_Done    = done_q;
    assign Bus_Error     = bus_error;

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed scenarios followed by random stimulus,
// all checked against a cycle-level behavioural model of the sequencing rules.
module tb_microsequencer;

    localparam int TMO  = 4;
    localparam int CMAX = 7;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Stall = 1'b0;
    logic [6:0] State_Sel = '0;
    logic [2:0] N_Sel = '0;
    logic [6:0] Cr_Addr = '0;
    logic [1:0] Cond_Sel = '0;
    logic       Cond_Inv = 1'b0;
    logic       Zero = 1'b0;
    logic       Neg = 1'b0;
    logic       MOC = 1'b0;
    logic [6:0] Current_State;
    logic       Illegal_Op;
    logic       Instr_Done;
    logic       Bus_Error;

    int total = 0;
    int bad   = 0;

    // model state
    int m_state = 0;
    int m_cnt   = 0;
    bit m_berr  = 0;
    bit m_ill   = 0;
    bit m_done  = 0;

    microsequencer #(.MOC_TIMEOUT(TMO)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Stall         (Stall),
        .State_Sel     (State_Sel),
        .N_Sel         (N_Sel),
        .Cr_Addr       (Cr_Addr),
        .Cond_Sel      (Cond_Sel),
        .Cond_Inv      (Cond_Inv),
        .Zero          (Zero),
        .Neg           (Neg),
        .MOC           (MOC),
        .Current_State (Current_State),
        .Illegal_Op    (Illegal_Op),
        .Instr_Done    (Instr_Done),
        .Bus_Error     (Bus_Error)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".state"}, int'(Current_State), m_state);
        chk({tag, ".ill"},   int'(Illegal_Op),    int'(m_ill));
        chk({tag, ".done"},  int'(Instr_Done),    int'(m_done));
        chk({tag, ".berr"},  int'(Bus_Error),     int'(m_berr));
    endtask

    // Behavioural model of one clock edge, derived from the sequencing rules.
    task automatic model_edge(input bit st, input int ns, input int ssel, input int cr,
                              input int cs, input bit ci, input bit z, input bit n,
                              input bit moc);
        bit c;
        m_ill  = 0;
        m_done = 0;
        if (m_berr || st) return;
        case (cs)
            0: c = 1;
            1: c = z;
            2: c = n;
            default: c = moc;
        endcase
        c = c ^ ci;
        if (ns != 4) m_cnt = 0;
        case (ns)
            0: m_state = (m_state + 1) % 128;
            1: if (ssel != 0) m_state = ssel;
               else begin m_state = 1; m_ill = 1; end
            2: m_state = cr;
            3: m_state = c ? cr : (m_state + 1) % 128;
            4: begin
                if (moc) begin
                    m_state = (m_state + 1) % 128;
                    m_cnt = 0;
                end else if (TMO != 0 && m_cnt == TMO - 1) begin
                    m_state = 127;
                    m_berr = 1;
                end else begin
                    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                end
            end
            5: begin m_state = 1; m_done = 1; end
            default: begin m_state = 1; m_ill = 1; end
        endcase
    endtask

    task automatic step(input string tag, input bit st, input int ns, input int ssel,
                        input int cr, input int cs, input bit ci, input bit z,
                        input bit n, input bit moc);
        Stall = st; N_Sel = 3'(ns); State_Sel = 7'(ssel); Cr_Addr = 7'(cr);
        Cond_Sel = 2'(cs); Cond_Inv = ci; Zero = z; Neg = n; MOC = moc;
        @(posedge Clk);
        model_edge(st, ns, ssel, cr, cs, ci, z, n, moc);
        #1;
        chk_model(tag);
    endtask

    // Asynchronous reset pulse between edges; checked before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        Reset_n = 1'b0;
        #1;
        m_state = 0; m_cnt = 0; m_berr = 0; m_ill = 0; m_done = 0;
        chk_model(tag);
        Reset_n = 1'b1;
    endtask

    initial begin
        // power-on reset
        repeat (2) @(posedge Clk);
        #1;
        chk_model("por");
        Reset_n = 1'b1;

        // increment sequence
        step("inc1", 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("inc1.const", int'(Current_State), 1);
        step("inc2", 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("inc2.const", int'(Current_State), 2);
        step("inc3", 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("inc3.const", int'(Current_State), 3);

        // illegal pulse then mid-run async reset clears it
        step("disp0a", 0, 1, 0, 0, 0, 0, 0, 0, 0); chk("disp0a.ill", int'(Illegal_Op), 1);
        async_reset("rst_mid");
        chk("rst_mid.const", int'(Current_State), 0);

        // wrap 127 -> 0
        step("jmp127", 0, 2, 0, 127, 0, 0, 0, 0, 0);
        step("wrap", 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("wrap.const", int'(Current_State), 0);

        // dispatch
        step("disp6", 0, 1, 6, 0, 0, 0, 0, 0, 0); chk("disp6.const", int'(Current_State), 6);
        step("disp0", 0, 1, 0, 0, 0, 0, 0, 0, 0); chk("disp0.const", int'(Illegal_Op), 1);
        step("disp0n", 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("disp0n.ill", int'(Illegal_Op), 0);

        // branches from state 10 to 40
        step("j10a", 0, 2, 0, 10, 0, 0, 0, 0, 0);
        step("brz", 0, 3, 0, 40, 1, 0, 1, 0, 0); chk("brz.const", int'(Current_State), 40);
        step("j10b", 0, 2, 0, 10, 0, 0, 0, 0, 0);
        step("brzi", 0, 3, 0, 40, 1, 1, 1, 0, 0); chk("brzi.const", int'(Current_State), 11);
        step("j10c", 0, 2, 0, 10, 0, 0, 0, 0, 0);
        step("brt", 0, 3, 0, 40, 0, 0, 0, 0, 0); chk("brt.const", int'(Current_State), 40);
        step("j10d", 0, 2, 0, 10, 0, 0, 0, 0, 0);
        step("brn", 0, 3, 0, 40, 2, 0, 0, 1, 0);

        // MOC wait: three low cycles then complete
        step("j13", 0, 2, 0, 13, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("wlow", 0, 4, 0, 0, 0, 0, 0, 0, 0);
        chk("whold.const", int'(Current_State), 13);
        step("wdone", 0, 4, 0, 0, 0, 0, 0, 0, 1);
        chk("wdone.const", int'(Current_State), 14);
        chk("wdone.berr", int'(Bus_Error), 0);

        // stall freezes state and the wait counter
        step("stinc", 1, 0, 0, 0, 0, 0, 0, 0, 0); chk("stinc.const", int'(Current_State), 14);
        step("j20", 0, 2, 0, 20, 0, 0, 0, 0, 0);
        step("w1", 0, 4, 0, 0, 0, 0, 0, 0, 0);
        step("w2", 0, 4, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("stw", 1, 4, 0, 0, 0, 0, 0, 0, 0);
        step("w3", 0, 4, 0, 0, 0, 0, 0, 0, 0);
        chk("w3.berr", int'(Bus_Error), 0);
        step("w4", 0, 4, 0, 0, 0, 0, 0, 0, 1); chk("w4.const", int'(Current_State), 21);

        // return and reserved modes
        step("ret", 0, 5, 0, 0, 0, 0, 0, 0, 0); chk("ret.done", int'(Instr_Done), 1);
        step("retn", 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("retn.done", int'(Instr_Done), 0);
        step("res6", 0, 6, 0, 0, 0, 0, 0, 0, 0);
        step("res7", 0, 7, 0, 0, 0, 0, 0, 0, 0);

        // watchdog timeout and sticky error
        step("j30", 0, 2, 0, 30, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("tmo", 0, 4, 0, 0, 0, 0, 0, 0, 0);
        chk("tmo.const", int'(Current_State), 127);
        chk("tmo.berr", int'(Bus_Error), 1);
        step("sticky1", 0, 2, 0, 5, 0, 0, 0, 0, 0);
        step("sticky2", 0, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("sticky.const", int'(Current_State), 127);
        async_reset("rst_err");

        // MOC arriving in the timeout cycle wins
        step("j30b", 0, 2, 0, 30, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("late", 0, 4, 0, 0, 0, 0, 0, 0, 0);
        step("lateok", 0, 4, 0, 0, 0, 0, 0, 0, 1);
        chk("lateok.const", int'(Current_State), 31);
        chk("lateok.berr", int'(Bus_Error), 0);

        // reset during a wait clears the counter
        step("j50", 0, 2, 0, 50, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("rw", 0, 4, 0, 0, 0, 0, 0, 0, 0);
        async_reset("rst_wait");
        step("j50b", 0, 2, 0, 50, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("rw2", 0, 4, 0, 0, 0, 0, 0, 0, 0);
        chk("rw2.berr", int'(Bus_Error), 0);

        // random stimulus
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd", ($urandom_range(0, 7) == 0),
                     int'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127)),
                     int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
